// File: rtl/i2s_audio_sink.sv
// i2s_audio_sink: one-entry sample buffer feeding a mono-to-stereo I2S serializer.
// Each accepted 16-bit sample is sent on both channels of one 32-slot frame.
// Optional feature macro: I2S_UNDERRUN_COUNT_EN builds the saturating underrun counter;
// without it underrun_count is tied to zero (underrun frames still output zeros).
module i2s_audio_sink #(
  parameter int unsigned BCLK_DIV = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample,
  input  logic        sample_valid,
  output logic        sink_ready,
  output logic        bclk,
  output logic        lrclk,
  output logic        sdata,
  output logic [15:0] underrun_count
);

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = 2 * SAMPLE_W;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned SLOT_W   = 5;

  logic [DIV_W-1:0]    div_cnt;
  logic                div_wrap;
  logic                slot_edge;
  logic [SLOT_W-1:0]   slot;
  logic [SLOT_W-1:0]   slot_next;
  logic [SLOT_W-1:0]   bit_idx;
  logic                frame_load;
  logic [FRAME_W-1:0]  frame_word;
  logic [SAMPLE_W-1:0] sample_buf;
  logic                buf_full;
  logic                handshake;

  assign sink_ready = ~buf_full;
  assign handshake  = sample_valid & ~buf_full;
  assign div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
  assign slot_edge  = div_wrap & bclk;
  assign slot_next  = slot + SLOT_W'(1);
  assign frame_load = slot_edge & (slot_next == '0);

  // Slot k shows frame_word[32-k]; for slot 0 the index wraps to 0, which picks bit 0
  // of the outgoing frame word (the one-bit I2S delay) since frame_word reloads on that edge.
  assign bit_idx = SLOT_W'(FRAME_W - 32'(slot_next));

  // Bit-clock divider: toggle bclk each time div_cnt wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Slot sequencer and serializer: advance and update lrclk/sdata on bclk falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot       <= '1;
      lrclk      <= 1'b0;
      sdata      <= 1'b0;
      frame_word <= '0;
    end else if (slot_edge) begin
      slot  <= slot_next;
      lrclk <= slot_next[SLOT_W-1];
      sdata <= frame_word[bit_idx];
      if (frame_load) begin
        frame_word <= buf_full ? {sample_buf, sample_buf} : '0;
      end
    end
  end

  // Holding buffer: a load consumes a full buffer; a handshake only fills an empty one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full   <= 1'b0;
      sample_buf <= '0;
    end else if (frame_load && buf_full) begin
      buf_full <= 1'b0;
    end else if (handshake) begin
      buf_full   <= 1'b1;
      sample_buf <= sample;
    end
  end

`ifdef I2S_UNDERRUN_COUNT_EN
  // Underrun counter: count frame loads that found the buffer empty, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (frame_load && !buf_full && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 16'(1);
    end
  end
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_i2s_audio_sink.sv
// Bench for i2s_audio_sink: two instances (BCLK_DIV 16 and 2) checked every cycle against a
// time-based model (output derived from edge count since reset and a list of frame words),
// plus directed literal checks of serialized frames.
module tb_i2s_audio_sink;

  localparam int D0 = 16;
  localparam int D1 = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sample0 = '0, sample1 = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic        ready0, ready1, bclk0, bclk1, lrclk0, lrclk1, sdata0, sdata1;
  logic [15:0] uc0, uc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  i2s_audio_sink #(.BCLK_DIV(D0)) dut0 (
    .clk(clk), .reset(reset), .sample(sample0), .sample_valid(valid0),
    .sink_ready(ready0), .bclk(bclk0), .lrclk(lrclk0), .sdata(sdata0),
    .underrun_count(uc0)
  );

  i2s_audio_sink #(.BCLK_DIV(D1)) dut1 (
    .clk(clk), .reset(reset), .sample(sample1), .sample_valid(valid1),
    .sink_ready(ready1), .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1),
    .underrun_count(uc1)
  );

  // Model state: edges since reset release, buffer, and the list of loaded frame words.
  int          mn[2];
  bit          mfull[2];
  logic [15:0] mbuf[2];
  logic [31:0] mframes[2][256];
  int          mnf[2];
  int          munder[2];

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got=%h expected=%h", nm, i, $time, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    int   d;
    bit   full_before;
    logic v;
    logic [15:0] s;
    d = (i == 0) ? D0 : D1;
    v = (i == 0) ? valid0 : valid1;
    s = (i == 0) ? sample0 : sample1;
    full_before = mfull[i];
    mn[i]++;
    // Frame loads happen at edge 2*d, then every 64*d edges.
    if (mn[i] >= 2 * d && ((mn[i] - 2 * d) % (64 * d)) == 0) begin
      if (full_before) begin
        mframes[i][mnf[i] % 256] = {mbuf[i], mbuf[i]};
        mfull[i] = 1'b0;
      end else begin
        mframes[i][mnf[i] % 256] = 32'h0;
        munder[i]++;
      end
      mnf[i]++;
    end
    if (v && !full_before) begin
      mbuf[i]  = s;
      mfull[i] = 1'b1;
    end
  endtask

  function automatic void model_out(input int i, output logic b, output logic l, output logic s,
                                    output logic r, output logic [15:0] u);
    int d, n, m, slot, f;
    d = (i == 0) ? D0 : D1;
    n = mn[i];
    b = ((n / d) % 2) == 1;
    l = 1'b0;
    s = 1'b0;
    if (n >= 2 * d) begin
      m    = n / (2 * d);
      slot = (m - 1) % 32;
      f    = (m - 1) / 32;
      l    = (slot >= 16);
      if (slot == 0) s = (f == 0) ? 1'b0 : mframes[i][(f - 1) % 256][0];
      else           s = mframes[i][f % 256][32 - slot];
    end
    r = !mfull[i];
`ifdef I2S_UNDERRUN_COUNT_EN
    u = (munder[i] > 65535) ? 16'hFFFF : 16'(munder[i]);
`else
    u = 16'h0;
`endif
  endfunction

  // Model update on every clock edge / asynchronous reset.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mn[i] = 0; mfull[i] = 1'b0; mnf[i] = 0; munder[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // Per-cycle compare at the falling edge.
  initial forever begin
    logic eb, el, es, er;
    logic [15:0] eu;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_out(i, eb, el, es, er, eu);
      chk("bclk",   i, 32'(i == 0 ? bclk0  : bclk1),  32'(eb));
      chk("lrclk",  i, 32'(i == 0 ? lrclk0 : lrclk1), 32'(el));
      chk("sdata",  i, 32'(i == 0 ? sdata0 : sdata1), 32'(es));
      chk("ready",  i, 32'(i == 0 ? ready0 : ready1), 32'(er));
      chk("urun",   i, 32'(i == 0 ? uc0    : uc1),    32'(eu));
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] cap0, capb, capz1, cap1, capz0, cap2, capr;
    int probs[4];
    int p0, p1;
    probs = '{0, 2, 10, 60};

    // Sample A5C3 then held-off 1234 on inst0; 8001 on inst1 (BCLK_DIV=2).
    do_reset();
    chk("rst_ready", 0, 32'(ready0), 32'h1);
    cap0 = '0; capb = '0; capz1 = '0; cap1 = '0;
    for (int n = 0; n <= 1600; n++) begin
      valid0  = (n >= 4 && n < 40);
      sample0 = (n < 5) ? 16'hA5C3 : 16'h1234;
      valid1  = (n >= 4 && n < 6);
      sample1 = 16'h8001;
      if (n == 4)   chk("ready_pre",  0, 32'(ready0), 32'h1);
      if (n == 5)   chk("ready_acc",  0, 32'(ready0), 32'h0);
      if (n == 31)  chk("bclk_hi31",  0, 32'(bclk0),  32'h1);
      if (n == 32)  chk("bclk_fall",  0, 32'(bclk0),  32'h0);
      if (n == 32)  chk("ready_load", 0, 32'(ready0), 32'h1);
      if (n == 33)  chk("ready_hold", 0, 32'(ready0), 32'h0);
      if (n == 543) chk("lr_left",    0, 32'(lrclk0), 32'h0);
      if (n == 544) chk("lr_right",   0, 32'(lrclk0), 32'h1);
      if (n >= 80 && n <= 1072 && (n % 32) == 16)   cap0  = {cap0[30:0], sdata0};
      if (n >= 1104 && n <= 1584 && (n % 32) == 16) capb  = {capb[30:0], sdata0};
      if (n >= 10 && n <= 134 && (n % 4) == 2)      capz1 = {capz1[30:0], sdata1};
      if (n >= 138 && n <= 262 && (n % 4) == 2)     cap1  = {cap1[30:0], sdata1};
      step();
    end
    chk("frame_a5c3", 0, cap0,  32'hA5C3A5C3);
    chk("frame_hold", 0, capb,  32'h00001234);
    chk("div2_zero",  1, capz1, 32'h0);
    chk("div2_8001",  1, cap1,  32'h80018001);

    // Sample first presented on the frame-load edge, then reset in slot 10 of frame 1.
    valid1 = 1'b0;
    do_reset();
    capz0 = '0; cap2 = '0;
    for (int n = 0; n < 1395; n++) begin
      valid0  = (n >= 31 && n < 33);
      sample0 = 16'h7E5A;
      if (n == 32) chk("sim_ready", 0, 32'(ready0), 32'h0);
`ifdef I2S_UNDERRUN_COUNT_EN
      if (n == 33) chk("sim_urun", 0, 32'(uc0), 32'h1);
`endif
      if (n >= 80 && n <= 560 && (n % 32) == 16)    capz0 = {capz0[30:0], sdata0};
      if (n >= 1104 && n <= 1360 && (n % 32) == 16) cap2  = {cap2[30:0], sdata0};
      step();
    end
    chk("sim_frame0", 0, capz0, 32'h0);
    chk("sim_frame1", 0, cap2,  32'h000000FC);
    chk("pre_rst_bclk",  0, 32'(bclk0),  32'h1);
    chk("pre_rst_sdata", 0, 32'(sdata0), 32'h1);
    reset = 1'b1;
    #1;
    chk("rst_bclk",  0, 32'(bclk0),  32'h0);
    chk("rst_sdata", 0, 32'(sdata0), 32'h0);
    chk("rst_lrclk", 0, 32'(lrclk0), 32'h0);
    chk("rst_rdy",   0, 32'(ready0), 32'h1);
    chk("rst_urun",  0, 32'(uc0),    32'h0);
    repeat (2) step();
    reset = 1'b0;

    // Idle after mid-frame reset: timing restarts, no residue, underruns accumulate.
    valid0 = 1'b0;
    capr = '0;
    for (int n = 0; n <= 2100; n++) begin
      if (n == 31) chk("re_bclk31", 0, 32'(bclk0), 32'h1);
      if (n == 32) chk("re_bclk32", 0, 32'(bclk0), 32'h0);
      if (n >= 80 && n <= 1072 && (n % 32) == 16) capr = {capr[30:0], sdata0};
`ifdef I2S_UNDERRUN_COUNT_EN
      if (n == 2080) chk("idle_urun", 0, 32'(uc0), 32'h3);
`else
      if (n == 2080) chk("idle_urun", 0, 32'(uc0), 32'h0);
`endif
      step();
    end
    chk("no_residue", 0, capr, 32'h0);

    // Randomized traffic with varying offered load and one reset.
    p0 = 0; p1 = 0;
    for (int n = 0; n < 6000; n++) begin
      if (n % 500 == 0) begin
        p0 = probs[$urandom_range(3)];
        p1 = probs[$urandom_range(3)];
      end
      valid0  = ($urandom_range(99) < p0);
      sample0 = 16'($urandom);
      valid1  = ($urandom_range(99) < p1);
      sample1 = 16'($urandom);
      if (n == 3000) reset = 1'b1;
      if (n == 3003) reset = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
